nand_exerciser: RTL and testbench

NAND_EXERCISER -- requirements
Module: nand_exerciser

---
 rtl/nand_exerciser.sv | 130 +++++++++++++
 tb/tb_nand_exerciser.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/nand_exerciser.sv
// nand_exerciser: sweeps the four input vectors of a 2-input NAND under test,
// waits a configurable settle time per vector, samples the response and
// accumulates mismatch statistics across single or looped sweeps.
module nand_exerciser #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       loop,
  input  logic       resp_y,
  output logic       stim_a,
  output logic       stim_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [3:0] fail_vec,
  output logic [7:0] sweep_count
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // Terminal value of the settle counter; unused when SETTLE_CYCLES is 0.
  localparam logic [3:0] SETTLE_LAST =
    (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] idx;
  logic [1:0] idx_inc;
  logic [3:0] settle_cnt;
  logic       mismatch;
  logic [7:0] err_nxt;

  assign idx_inc = idx + 2'd1;

  // The response is only looked at in SAMPLE; stim is stable there because
  // it was registered on entry to DRIVE.
  assign mismatch = (state == SAMPLE) && (resp_y != ~(stim_a & stim_b));

  // Saturating error count including the vector currently being sampled.
  assign err_nxt = (mismatch && (err_count != 8'hFF)) ? err_count + 8'd1
                                                      : err_count;

  // Next-state decode for the sweep sequencer.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == 2'd3) ? DONE : DRIVE;
      DONE:    state_nxt = loop ? DRIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus all registered outputs and sweep statistics.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout so every register samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      settle_cnt  <= 4'd0;
      stim_a      <= 1'b0;
      stim_b      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= 8'd0;
      fail_vec    <= 4'd0;
      sweep_count <= 8'd0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            idx         <= 2'd0;
            stim_a      <= 1'b0;
            stim_b      <= 1'b0;
            pass        <= 1'b0;
            err_count   <= 8'd0;
            fail_vec    <= 4'd0;
            sweep_count <= 8'd0;
          end
        end
        DRIVE: begin
          settle_cnt <= 4'd0;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
        end
        SAMPLE: begin
          err_count <= err_nxt;
          if (mismatch) fail_vec[idx] <= 1'b1;
          if (idx != 2'd3) begin
            // Next vector goes out on the edge that enters DRIVE.
            idx    <= idx_inc;
            stim_a <= idx_inc[0];
            stim_b <= idx_inc[1];
          end else begin
            // Sweep result is visible during the DONE cycle itself.
            pass        <= (err_nxt == 8'd0);
            sweep_count <= sweep_count + 8'd1;
          end
        end
        DONE: begin
          // Restart the vector order for a looped sweep, or park stim at 00.
          idx    <= 2'd0;
          stim_a <= 1'b0;
          stim_b <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_exerciser.sv
// tb_nand_exerciser: drives the exerciser against a faulty-NAND model whose
// errors are described by a 4-bit mask (bit i flips the response of vector i)
// and checks timing and statistics predicted from the sweep arithmetic.
module tb_nand_exerciser;

  localparam int S = 2;
  localparam int P = 4 * (S + 2) + 1;   // cycles from start to DONE / loop period

  logic       clk = 1'b0;
  logic       rst, start, loop, resp_y;
  logic       stim_a, stim_b, busy, done, pass;
  logic [7:0] err_count, sweep_count;
  logic [3:0] fail_vec;
  logic [3:0] mask;

  int n_checks = 0;
  int n_errors = 0;

  nand_exerciser #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .loop       (loop),
    .resp_y     (resp_y),
    .stim_a     (stim_a),
    .stim_b     (stim_b),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_vec   (fail_vec),
    .sweep_count(sweep_count)
  );

  always #5 clk = ~clk;

  // Device under test: a NAND with the vectors selected by mask inverted.
  assign resp_y = ~(stim_a & stim_b) ^ mask[{stim_b, stim_a}];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_err(input int sweeps, input logic [3:0] m);
    int e;
    e = sweeps * $countones(m);
    return (e > 255) ? 255 : e;
  endfunction

  // Run n sweeps (looping n-1 times) with the given fault mask, checking
  // every cycle. start and loop are randomized wherever they must be ignored.
  task automatic run(input logic [3:0] m, input int n);
    int s, o, k;
    mask  = m;
    @(negedge clk);
    start = 1'b1;
    loop  = 1'($urandom);
    @(posedge clk);                       // cycle 0: start seen
    for (int c = 1; c <= n * P; c++) begin
      @(negedge clk);
      s = (c - 1) / P;
      o = c - s * P;
      if (c == 1) begin
        check("start_clear", {pass, err_count, fail_vec, sweep_count}, 32'd0);
      end
      if (o < P) begin
        k = (o - 1) / (S + 2);
        check("sweep_ctl", {busy, done, stim_b, stim_a}, {2'b10, 2'(k)});
      end else begin
        check("done_ctl", {busy, done}, 2'b11);
        check("err_count", err_count, exp_err(s + 1, m));
        check("fail_vec", fail_vec, m);
        check("sweep_count", sweep_count, 8'((s + 1) % 256));
        check("pass", pass, (m == 4'd0));
      end
      if (o == P) begin
        loop  = (s < n - 1);
        start = (s < n - 1) ? 1'($urandom) : 1'b0;
      end else begin
        loop  = 1'($urandom);
        start = 1'($urandom);
      end
    end
    @(negedge clk);
    check("idle_ctl", {busy, done, stim_b, stim_a}, 4'b0000);
    check("idle_err", err_count, exp_err(n, m));
    check("idle_sweeps", sweep_count, 8'(n % 256));
    check("idle_pass", pass, (m == 4'd0));
    start = 1'b0;
    loop  = 1'b0;
    @(negedge clk);
    check("stay_idle", busy, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    loop  = 1'b0;
    mask  = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", {busy, done, pass, stim_b, stim_a, err_count, fail_vec, sweep_count},
          32'd0);
    rst = 1'b0;

    run(4'b0000, 1);    // ideal NAND
    run(4'b1111, 1);    // AND behaviour: every vector wrong
    run(4'b1000, 1);    // output stuck at 1: only vector 11 wrong
    run(4'b1000, 3);    // looped stuck-at-1

    // Reset mid-sweep, asserted together with start and loop.
    mask = 4'b1111;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'($urandom);
    end
    check("pre_rst_err", err_count, 32'd1);
    rst   = 1'b1;
    start = 1'b1;
    loop  = 1'b1;
    @(negedge clk);
    check("mid_rst", {busy, done, pass, stim_b, stim_a, err_count, fail_vec, sweep_count},
          32'd0);
    rst   = 1'b0;
    start = 1'b0;
    loop  = 1'b0;
    @(negedge clk);
    check("post_rst_idle", busy, 1'b0);

    run(4'b1111, 64);   // saturation of err_count

    for (int i = 0; i < 4; i++) begin
      run(4'($urandom), int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
